// File: rtl/sys_mem_pkg.sv
// Shared definitions for the partition-manager local bus: register map,
// result codes and the initiator's sequencing states.
package sys_mem_pkg;

   localparam logic [7:0] CNTRL_REG      = 8'h00;
   localparam logic [7:0] NUM_AGENTS_REG = 8'h01;
   localparam logic [7:0] ADDR_REG       = 8'h02;
   localparam logic [7:0] START_DATA_REG = 8'h03;
   localparam logic [7:0] END_DATA_REG   = 8'h04;

   typedef enum logic [2:0] {
      OK           = 3'd0,
      NUM_MISMATCH = 3'd1,
      RB_MISMATCH  = 3'd2,
      TIMEOUT      = 3'd3,
      RANGE        = 3'd4
   } err_code_t;

   typedef enum logic [3:0] {
      IDLE, CHK_NUM, SET_CFG, WR_ADDR, WR_START, WR_END,
      SETTLE, RD_START, RD_END, CLR_CFG, DONE
   } init_state_t;

endpackage

// File: rtl/sys_mem_part_init_if.sv
// Local-bus signal bundle between the partition initiator (master) and the
// partition manager register block (slave).
interface sys_mem_part_init_if #(
   parameter int LB_ADDR_W = 8,
   parameter int LB_DATA_W = 32
);
   logic                 lb_wr_en;
   logic                 lb_rd_en;
   logic [LB_ADDR_W-1:0] lb_addr;
   logic [LB_DATA_W-1:0] lb_wr_data;
   logic                 lb_wr_valid;
   logic                 lb_rd_valid;
   logic [LB_DATA_W-1:0] lb_rd_data;

   modport master (
      output lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
      input  lb_wr_valid, lb_rd_valid, lb_rd_data
   );

   modport slave (
      input  lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
      output lb_wr_valid, lb_rd_valid, lb_rd_data
   );
endinterface

// File: rtl/lb_mstr_xtn.sv
// Issues one local-bus transaction per req pulse and tracks its completion
// or timeout; address/data stay driven until the transaction resolves.
module lb_mstr_xtn #(
   parameter int LB_DATA_W      = 32,
   parameter int LB_ADDR_W      = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req,
   input  logic                 req_wr,
   input  logic [LB_ADDR_W-1:0] req_addr,
   input  logic [LB_DATA_W-1:0] req_data,
   output logic                 xtn_done,
   output logic                 xtn_timeout,
   output logic [LB_DATA_W-1:0] rd_data,
   sys_mem_part_init_if.master  lb
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic                 pend_reg;
   logic                 wr_reg;
   logic                 wr_en_reg;
   logic                 rd_en_reg;
   logic [LB_ADDR_W-1:0] addr_reg;
   logic [LB_DATA_W-1:0] data_reg;
   logic [CNT_W-1:0]     cnt_reg;

   // Valids count only while a transaction is outstanding.
   assign xtn_done    = pend_reg && (wr_reg ? lb.lb_wr_valid : lb.lb_rd_valid);
   assign xtn_timeout = pend_reg && !xtn_done && (cnt_reg == CNT_W'(TIMEOUT_CYCLES));
   assign rd_data     = lb.lb_rd_data;

   assign lb.lb_wr_en   = wr_en_reg;
   assign lb.lb_rd_en   = rd_en_reg;
   assign lb.lb_addr    = addr_reg;
   assign lb.lb_wr_data = data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg  <= 1'b0;
         wr_reg    <= 1'b0;
         wr_en_reg <= 1'b0;
         rd_en_reg <= 1'b0;
         addr_reg  <= '0;
         data_reg  <= '0;
         cnt_reg   <= '0;
      end else begin
         wr_en_reg <= 1'b0;
         rd_en_reg <= 1'b0;
         if (req) begin
            pend_reg  <= 1'b1;
            wr_reg    <= req_wr;
            wr_en_reg <= req_wr;
            rd_en_reg <= !req_wr;
            addr_reg  <= req_addr;
            data_reg  <= req_wr ? req_data : '0;
            cnt_reg   <= '0;
         end else if (xtn_done || xtn_timeout) begin
            pend_reg <= 1'b0;
            addr_reg <= '0;
            data_reg <= '0;
            cnt_reg  <= '0;
         end else if (pend_reg) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/sys_mem_part_init.sv
// Programs the partition manager's per-agent start/end tables over the local
// bus, verifying agent count up front and every table entry by readback.
module sys_mem_part_init
   import sys_mem_pkg::*;
#(
   parameter int  MEM_ADDR_W     = 27,
   parameter int  NUM_AGENTS     = 2,
   parameter int  LB_DATA_W      = 32,
   parameter int  LB_ADDR_W      = 8,
   parameter int  TIMEOUT_CYCLES = 16,
   localparam int AGENT_ID_W     = $clog2(NUM_AGENTS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [MEM_ADDR_W-1:0] base_addr,
   input  logic [MEM_ADDR_W-1:0] part_size,
   output logic                  busy,
   output logic                  done,
   output logic [2:0]            err_code,
   sys_mem_part_init_if.master   lb
);
   localparam int LIM_W = MEM_ADDR_W + AGENT_ID_W + 1;
   localparam int IDX_W = (AGENT_ID_W > 0) ? AGENT_ID_W : 1;

   init_state_t           state_reg, state_next;
   logic                  phase_reg, phase_next;
   err_code_t             err_reg, err_next;
   logic [MEM_ADDR_W-1:0] base_reg, base_next;
   logic [MEM_ADDR_W-1:0] size_reg, size_next;
   logic [MEM_ADDR_W-1:0] cur_reg, cur_next;
   logic [IDX_W-1:0]      idx_reg, idx_next;

   logic                  req, req_wr, is_lb;
   logic [LB_ADDR_W-1:0]  req_addr;
   logic [LB_DATA_W-1:0]  req_data;
   logic                  xtn_done, xtn_timeout;
   logic [LB_DATA_W-1:0]  rd_data;
   logic [LIM_W-1:0]      lim;
   logic                  range_bad;
   logic [MEM_ADDR_W-1:0] end_val;

   // Extra width keeps the end-of-last-partition sum from wrapping.
   assign lim       = LIM_W'(base_addr) + LIM_W'(NUM_AGENTS) * LIM_W'(part_size);
   assign range_bad = (lim > (LIM_W'(1) << MEM_ADDR_W)) || (part_size == '0);
   assign end_val   = cur_reg + size_reg - MEM_ADDR_W'(1);

   assign busy     = (state_reg != IDLE);
   assign done     = (state_reg == DONE);
   assign err_code = err_reg;

   lb_mstr_xtn #(
      .LB_DATA_W      (LB_DATA_W),
      .LB_ADDR_W      (LB_ADDR_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_xtn (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_wr      (req_wr),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .xtn_done    (xtn_done),
      .xtn_timeout (xtn_timeout),
      .rd_data     (rd_data),
      .lb          (lb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         phase_reg <= 1'b0;
         err_reg   <= OK;
         base_reg  <= '0;
         size_reg  <= '0;
         cur_reg   <= '0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         err_reg   <= err_next;
         base_reg  <= base_next;
         size_reg  <= size_next;
         cur_reg   <= cur_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg;
      err_next   = err_reg;
      base_next  = base_reg;
      size_next  = size_reg;
      cur_next   = cur_reg;
      idx_next   = idx_reg;
      req        = 1'b0;
      req_wr     = 1'b1;
      req_addr   = '0;
      req_data   = '0;
      is_lb      = 1'b1;

      // Transaction descriptor for each bus state; phase 0 issues, phase 1 waits.
      case (state_reg)
         CHK_NUM:  begin req_wr = 1'b0; req_addr = LB_ADDR_W'(NUM_AGENTS_REG); end
         SET_CFG:  begin req_addr = LB_ADDR_W'(CNTRL_REG); req_data = LB_DATA_W'(1); end
         WR_ADDR:  begin req_addr = LB_ADDR_W'(ADDR_REG); req_data = LB_DATA_W'(idx_reg); end
         WR_START: begin req_addr = LB_ADDR_W'(START_DATA_REG); req_data = LB_DATA_W'(cur_reg); end
         WR_END:   begin req_addr = LB_ADDR_W'(END_DATA_REG); req_data = LB_DATA_W'(end_val); end
         RD_START: begin req_wr = 1'b0; req_addr = LB_ADDR_W'(START_DATA_REG); end
         RD_END:   begin req_wr = 1'b0; req_addr = LB_ADDR_W'(END_DATA_REG); end
         CLR_CFG:  begin req_addr = LB_ADDR_W'(CNTRL_REG); end
         default:  is_lb = 1'b0;
      endcase

      if (is_lb) begin
         if (!phase_reg) begin
            req        = 1'b1;
            phase_next = 1'b1;
         end else if (xtn_timeout) begin
            err_next   = TIMEOUT;
            state_next = DONE;
            phase_next = 1'b0;
         end else if (xtn_done) begin
            phase_next = 1'b0;
            case (state_reg)
               CHK_NUM: begin
                  if (rd_data != LB_DATA_W'(NUM_AGENTS)) begin
                     err_next   = NUM_MISMATCH;
                     state_next = DONE;
                  end else begin
                     state_next = SET_CFG;
                  end
               end
               SET_CFG: begin
                  idx_next   = '0;
                  cur_next   = base_reg;
                  state_next = WR_ADDR;
               end
               WR_ADDR:  state_next = WR_START;
               WR_START: state_next = WR_END;
               WR_END:   state_next = SETTLE;
               RD_START: begin
                  if (rd_data != LB_DATA_W'(cur_reg)) begin
                     err_next   = RB_MISMATCH;
                     state_next = CLR_CFG;
                  end else begin
                     state_next = RD_END;
                  end
               end
               RD_END: begin
                  if (rd_data != LB_DATA_W'(end_val)) begin
                     err_next   = RB_MISMATCH;
                     state_next = CLR_CFG;
                  end else if (idx_reg == IDX_W'(NUM_AGENTS - 1)) begin
                     state_next = CLR_CFG;
                  end else begin
                     idx_next   = idx_reg + IDX_W'(1);
                     cur_next   = cur_reg + size_reg;
                     state_next = WR_ADDR;
                  end
               end
               default: state_next = DONE;
            endcase
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  base_next  = base_addr;
                  size_next  = part_size;
                  phase_next = 1'b0;
                  err_next   = range_bad ? RANGE : OK;
                  state_next = range_bad ? DONE : CHK_NUM;
               end
            end
            // Phase bit doubles as the two-cycle table-RAM settle counter.
            SETTLE: begin
               if (phase_reg) begin
                  phase_next = 1'b0;
                  state_next = RD_START;
               end else begin
                  phase_next = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end
endmodule
